// File: rtl/kalman_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined signed fixed-point multiplier between requesters.
// Optional feature: define MUL_SAT_EN to clamp out-of-range results and record them in sat_flag.
module kalman_mul_arbiter #(
  parameter  int N_REQ  = 4,
  parameter  int DATA_W = 16,
  parameter  int FRAC_W = 13,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] a_in,
  input  logic [N_REQ*DATA_W-1:0] b_in,
  output logic [N_REQ-1:0]        gnt,
  input  logic                    flush,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    busy,
  output logic                    sat_flag,
  input  logic                    sat_clr
);
  localparam int PROD_W = 2 * DATA_W;

`ifdef MUL_SAT_EN
  localparam logic signed [PROD_W-1:0] SAT_MAX = {{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] SAT_MIN = {{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [ID_W-1:0]          grant_id;
  logic [ID_W-1:0]          idx;
  logic                     found;
  logic                     accept;

  logic                     s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]          s1_id_q, s1_id_d;
  logic [DATA_W-1:0]        s1_a_q, s1_a_d;
  logic [DATA_W-1:0]        s1_b_q, s1_b_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [ID_W-1:0]          s2_id_q, s2_id_d;
  logic signed [PROD_W-1:0] s2_prod_q, s2_prod_d;
  logic                     s3_valid_q, s3_valid_d;
  logic [ID_W-1:0]          s3_id_q, s3_id_d;
  logic [DATA_W-1:0]        s3_data_q, s3_data_d;
  logic                     rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]        rsp_data_q, rsp_data_d;
  logic                     sat_flag_q, sat_flag_d;
  logic signed [PROD_W-1:0] shifted;
  logic                     clamp;

  // First active requester searching upward from ptr+1; nothing is granted in reset or flush.
  always_comb begin
    gnt      = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    if (reset && !flush) begin
      for (int off = 1; off <= N_REQ; off++) begin
        idx = ID_W'((int'(ptr_q) + off) % N_REQ);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          grant_id = idx;
        end
      end
    end
  end

  assign accept = |gnt;

  always_comb begin
    ptr_d      = accept ? grant_id : ptr_q;
    s1_valid_d = accept;
    s1_id_d    = accept ? grant_id : s1_id_q;
    s1_a_d     = accept ? a_in[int'(grant_id)*DATA_W +: DATA_W] : s1_a_q;
    s1_b_d     = accept ? b_in[int'(grant_id)*DATA_W +: DATA_W] : s1_b_q;

    s2_valid_d = s1_valid_q && !flush;
    s2_id_d    = s1_id_q;
    s2_prod_d  = {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q} * {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q};

    // Arithmetic shift floors toward negative infinity; no rounding term is added.
    shifted    = s2_prod_q >>> FRAC_W;
    clamp      = 1'b0;
`ifdef MUL_SAT_EN
    if (shifted > SAT_MAX) begin
      s3_data_d = SAT_MAX[DATA_W-1:0];
      clamp     = 1'b1;
    end else if (shifted < SAT_MIN) begin
      s3_data_d = SAT_MIN[DATA_W-1:0];
      clamp     = 1'b1;
    end else begin
      s3_data_d = DATA_W'(shifted);
    end
`else
    s3_data_d  = DATA_W'(shifted);
`endif
    s3_valid_d = s2_valid_q && !flush;
    s3_id_d    = s2_id_q;

    rsp_valid_d = s3_valid_q && !flush;
    rsp_id_d    = rsp_valid_d ? s3_id_q : rsp_id_q;
    rsp_data_d  = rsp_valid_d ? s3_data_q : rsp_data_q;

    // A clamp on the same edge as sat_clr leaves the flag set.
    sat_flag_d = (sat_flag_q && !sat_clr) || (s2_valid_q && !flush && clamp);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= ID_W'(N_REQ - 1);
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_id_q     <= '0;
      s2_prod_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_id_q     <= '0;
      s3_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      sat_flag_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      s1_valid_q  <= s1_valid_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_id_q     <= s2_id_d;
      s2_prod_q   <= s2_prod_d;
      s3_valid_q  <= s3_valid_d;
      s3_id_q     <= s3_id_d;
      s3_data_q   <= s3_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = s1_valid_q || s2_valid_q || s3_valid_q;
  assign sat_flag  = sat_flag_q;

endmodule
